// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - word-organised data SRAM responder with byte enables, range check and post-reset clear
// Optional write-first read-back on write cycles: define DSRAM_WRITE_FIRST_EN.
module data_sram_responder #(
    parameter int ADDR_W     = 11,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        ready,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              addr_err_q, addr_err_d;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic [31:0]       old_word;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              unused_addr_lsbs;

    assign idx              = data_sram_addr[ADDR_W+1:2];
    assign in_range         = (data_sram_addr[31:ADDR_W+2] == '0);
    assign old_word         = mem[idx];
    assign unused_addr_lsbs = ^data_sram_addr[1:0];

`ifdef DSRAM_WRITE_FIRST_EN
    logic [31:0] merged;
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
                merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_CLEAR ? S_INIT : S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave INIT on the cycle the last word is cleared
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && (&cnt_q)) begin
            state_d = S_RUN;
        end
    end

    // Output / datapath control
    always_comb begin
        cnt_d      = cnt_q;
        ready_d    = (state_d == S_RUN);
        rdata_d    = rdata_q;
        addr_err_d = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = idx;
        wr_be      = 4'h0;
        wr_data    = data_sram_wdata;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_be   = 4'hF;
                wr_data = 32'h0;
                cnt_d   = cnt_q + 1'b1;
                rdata_d = 32'h0;
            end
            default: begin
                if (data_sram_en) begin
                    if (in_range) begin
                        wr_en = |data_sram_wen;
                        wr_be = data_sram_wen;
`ifdef DSRAM_WRITE_FIRST_EN
                        rdata_d = (|data_sram_wen) ? merged : old_word;
`else
                        rdata_d = old_word;
`endif
                    end else begin
                        rdata_d    = 32'h0;
                        addr_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array is never reset directly; the clear sequencer zeroes it instead
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign ready           = ready_q;
    assign addr_err        = addr_err_q;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the CPU data-SRAM interface: accepts en/wen/addr/wdata from the load/store bridge and returns read data one cycle later.
- Word-organised on-chip memory with per-byte write enables and out-of-range detection.
- Post-reset clear sequencer zeroes the array before accepting traffic.
- Sits between the load/store bridge and the memory subsystem; also serves as the bench/FPGA data memory.

Parameters:
- ADDR_W, 11, word-address width; depth = 2^ADDR_W words (default 2048 words = 8 KB).
- INIT_CLEAR, 1, 1 = zero the array after reset before asserting ready; 0 = skip clear.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- data_sram_en  input  1  access request this cycle
- data_sram_wen  input  4  byte write enables; bit i writes lane i (wdata[8i+7:8i]); 0000 = read
- data_sram_addr  input  32  byte address, already rebased to 0; bits [1:0] ignored
- data_sram_wdata  input  32  write data, lane-replicated by initiator
- data_sram_rdata  output  32  registered read data
- ready  output  1  high once array is usable
- addr_err  output  1  one-cycle pulse aligned with rdata for an out-of-range access

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: data_sram_rdata = 0, addr_err = 0, ready = 0, state = INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0), clear counter = 0. Array contents are not reset directly.
- FSM states: INIT and RUN.
  - INIT: each cycle write 0 to word[cnt]; cnt increments.
  - INIT to RUN on the cycle cnt == 2^ADDR_W-1 is written; ready rises the following cycle.
  - Clear takes exactly 2^ADDR_W cycles after rst falls.
  - With INIT_CLEAR=0, ready is 1 in the first cycle after rst falls.
- Reset during INIT restarts the clear from cnt = 0. Reset during RUN returns to INIT and re-clears (INIT_CLEAR=1).
- In INIT, requests are ignored: no write, rdata forced to 0, addr_err stays 0.
- Index and range: word index = addr[ADDR_W+1:2]. An access is in range when addr[31:ADDR_W+2] == 0.
- Read (en=1, wen=0000, in range): data_sram_rdata = word[index] at the next edge. Latency is 1 cycle.
- Write (en=1, wen!=0, in range): at the edge, only enabled byte lanes of word[index] are updated. Disabled lanes keep their old value.
  - rdata for a write cycle: old word (read-first), unless the optional feature is enabled.
- Out-of-range access: no array update. Next cycle rdata = 0 and addr_err = 1 for exactly one cycle.
- en=0: rdata holds its previous value, addr_err = 0, no array update. wen is ignored when en=0.
- Back-to-back accesses are accepted every cycle; there is no stall.
- Write followed by read of the same word in the next cycle returns the updated word.
- Highest word (index 2^ADDR_W-1) is valid. The first address past it (addr = 2^(ADDR_W+2)) is out-of-range, with no wrap to index 0.

Optional Feature:
- Macro: DSRAM_WRITE_FIRST_EN.
- Defined: for an in-range write cycle, next-cycle rdata is the merged word (enabled lanes from wdata, others from the old word), i.e. write-first.
- Undefined: rdata for a write cycle is the pre-write word (read-first).
- Reads, out-of-range handling and INIT behaviour are identical either way.

Test Plan:
- Reset, INIT_CLEAR=1, ADDR_W=4: hold rst 2 cycles, release → ready = 0 for 16 cycles then 1. Read addr 0x3C → rdata = 0x00000000.
- RUN, sw: en=1, wen=1111, addr=0x10, wdata=0x12345678; next cycle read 0x10 → rdata = 0x12345678 one cycle after the request.
- Byte lanes: word 0x10 = 0x12345678; write wen=0100, wdata=0xABABABAB; read → 0x12AB5678. Then write wen=1100, wdata=0xBEEFBEEF → 0xBEEF5678.
- Range, ADDR_W=4: read addr 0x40 → rdata 0, addr_err pulses exactly 1 cycle. Write 0x40 with wen=1111 → word 0 unchanged on re-read.
- Write-cycle rdata: word 0x20 = 0x11111111; write wen=0001, wdata=0x000000FF → rdata next cycle = 0x11111111 without the macro, 0x111111FF with DSRAM_WRITE_FIRST_EN.
- Reset mid-INIT: assert rst at clear cycle 7, release → ready rises exactly 16 cycles after release. Requests during INIT leave rdata = 0 and addr_err = 0.
